// File: rtl/sdram_rw_port.sv
// Buffered SDRAM access port: posted write FIFO with auto-incrementing addresses,
// prefetching read FIFO, and a single-outstanding req/ack arbiter that favours writes.
module sdram_rw_port #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_ld,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic              write_req,
    input  logic [DATA_W-1:0] writedata,
    output logic [15:0]       wr_buffer,
    output logic              wr_ovf,
    input  logic              read_ld,
    input  logic [ADDR_W-1:0] readaddr,
    input  logic              read_req,
    output logic [DATA_W-1:0] readdata,
    output logic [15:0]       rd_buffer,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] wf_addr [DEPTH];
    logic [DATA_W-1:0] wf_data [DEPTH];
    logic [PW-1:0]     wf_wp, wf_rp;
    logic [CW-1:0]     wf_cnt;
    logic [ADDR_W-1:0] waddr, waddr_cur;
    logic              wf_full, wf_push, wf_pop;

    logic [DATA_W-1:0] rf_data [DEPTH];
    logic [PW-1:0]     rf_wp, rf_rp;
    logic [CW-1:0]     rf_cnt;
    logic [ADDR_W-1:0] raddr;
    logic              rf_push, rf_pop;
    logic              pf_en, discard, pf_issue;

    logic              req_nx, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;

    // Write side: a same-cycle write_ld redirects the push to the new address.
    assign waddr_cur = write_ld ? writeaddr : waddr;
    assign wf_full   = (wf_cnt == CW'(DEPTH));
    assign wf_push   = write_req && !wf_full;
    assign wf_pop    = (state == S_WR) && mem_ack;
    assign wr_buffer = 16'(wf_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr  <= '0;
            wf_wp  <= '0;
            wf_rp  <= '0;
            wf_cnt <= '0;
            wr_ovf <= 1'b0;
        end else begin
            if (wf_push) begin
                waddr <= waddr_cur + ADDR_W'(1);
                wf_wp <= wf_wp + PW'(1);
            end else if (write_ld) begin
                waddr <= writeaddr;
            end
            if (wf_pop) begin
                wf_rp <= wf_rp + PW'(1);
            end
            if (wf_push && !wf_pop) begin
                wf_cnt <= wf_cnt + CW'(1);
            end else if (!wf_push && wf_pop) begin
                wf_cnt <= wf_cnt - CW'(1);
            end
            if (write_ld) begin
                wr_ovf <= 1'b0;
            end
            if (write_req && wf_full) begin
                wr_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wf_push) begin
            wf_addr[wf_wp] <= waddr_cur;
            wf_data[wf_wp] <= writedata;
        end
    end

    // Read side: read_ld flushes and wins over a same-cycle pop or returning word.
    assign rf_push   = (state == S_RWAIT) && mem_rvalid && !discard && !read_ld;
    assign rf_pop    = read_req && !read_ld && (rf_cnt != '0);
    assign readdata  = (rf_cnt != '0) ? rf_data[rf_rp] : '0;
    assign rd_buffer = 16'(rf_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr   <= '0;
            rf_wp   <= '0;
            rf_rp   <= '0;
            rf_cnt  <= '0;
            pf_en   <= 1'b0;
            discard <= 1'b0;
        end else if (read_ld) begin
            raddr   <= readaddr;
            rf_wp   <= '0;
            rf_rp   <= '0;
            rf_cnt  <= '0;
            pf_en   <= 1'b1;
            discard <= (state == S_RD) || ((state == S_RWAIT) && !mem_rvalid);
        end else begin
            if ((state == S_RD) && mem_ack) begin
                raddr <= raddr + ADDR_W'(1);
            end
            if ((state == S_RWAIT) && mem_rvalid) begin
                discard <= 1'b0;
            end
            if (rf_push) begin
                rf_wp <= rf_wp + PW'(1);
            end
            if (rf_pop) begin
                rf_rp <= rf_rp + PW'(1);
            end
            if (rf_push && !rf_pop) begin
                rf_cnt <= rf_cnt + CW'(1);
            end else if (!rf_push && rf_pop) begin
                rf_cnt <= rf_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rf_push) begin
            rf_data[rf_wp] <= mem_rdata;
        end
    end

    // Only evaluated in IDLE, where nothing is outstanding.
    assign pf_issue = pf_en && !read_ld && (wf_cnt == '0) && (rf_cnt < CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
        end
    end

    // Arbiter: writes always take priority over prefetch reads.
    always_comb begin
        state_nx = state;
        req_nx   = mem_req;
        we_nx    = mem_we;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        case (state)
            S_IDLE: begin
                if (wf_cnt != '0) begin
                    state_nx = S_WR;
                    req_nx   = 1'b1;
                    we_nx    = 1'b1;
                    addr_nx  = wf_addr[wf_rp];
                    wdata_nx = wf_data[wf_rp];
                end else if (pf_issue) begin
                    state_nx = S_RD;
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    addr_nx  = raddr;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_nx = S_IDLE;
                    req_nx   = 1'b0;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    state_nx = S_RWAIT;
                    req_nx   = 1'b0;
                end
            end
            S_RWAIT: begin
                if (mem_rvalid) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_rw_port.sv
// Bench for sdram_rw_port: behavioural SDRAM responder with write scoreboard,
// table-driven write-side vectors, and directed read/arbitration/reset sequences.
module tb_sdram_rw_port;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;

    logic              clk;
    logic              reset;
    logic              write_ld;
    logic [ADDR_W-1:0] writeaddr;
    logic              write_req;
    logic [DATA_W-1:0] writedata;
    logic [15:0]       wr_buffer;
    logic              wr_ovf;
    logic              read_ld;
    logic [ADDR_W-1:0] readaddr;
    logic              read_req;
    logic [DATA_W-1:0] readdata;
    logic [15:0]       rd_buffer;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    sdram_rw_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .write_ld(write_ld), .writeaddr(writeaddr), .write_req(write_req), .writedata(writedata),
        .wr_buffer(wr_buffer), .wr_ovf(wr_ovf),
        .read_ld(read_ld), .readaddr(readaddr), .read_req(read_req), .readdata(readdata),
        .rd_buffer(rd_buffer),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: explicit entries, else an address-derived pattern.
    logic [15:0] mem [int unsigned];

    function automatic logic [15:0] mem_val(input logic [ADDR_W-1:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return 16'(a) ^ 16'h5A5A;
    endfunction

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } txn_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wexp_t;

    txn_t        log_q [$];
    wexp_t       exp_wr [$];
    logic [15:0] rd_exp [$];

    bit                ack_en  = 1'b1;
    bit                rv_hold = 1'b0;
    bit                rv_pend = 1'b0;
    int                rv_cnt  = 0;
    logic [ADDR_W-1:0] rv_addr;
    bit                rd_acked = 1'b0;
    logic [ADDR_W-1:0] rd_ack_addr;
    logic              prev_req;
    logic [41:0]       prev_bus;
    wexp_t             rsp_w;

    // Controller model: 1-cycle ack, rvalid two cycles after ack; a pending
    // rvalid survives reset so a stray return can be injected afterwards.
    always @(posedge clk) begin
        mem_ack    <= 1'b0;
        mem_rvalid <= 1'b0;
        if (rv_pend && !rv_hold) begin
            if (rv_cnt <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_val(rv_addr);
                rv_pend = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (!reset) begin
            if (prev_req && mem_req)
                chk("mem_bus_stable", 32'({mem_we, mem_addr, mem_wdata} != prev_bus), 32'(0));
            if (mem_req && !mem_ack && ack_en) begin
                mem_ack <= 1'b1;
                log_q.push_back('{mem_we, mem_addr});
                if (mem_we) begin
                    mem[32'(mem_addr)] = mem_wdata;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got write 0x%0h/0x%0h required none", mem_addr, mem_wdata);
                    end else begin
                        rsp_w = exp_wr.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(rsp_w.addr));
                        chk("wr_data", 32'(mem_wdata), 32'(rsp_w.data));
                    end
                end else begin
                    rd_acked    = 1'b1;
                    rd_ack_addr = mem_addr;
                    rv_pend     = 1'b1;
                    rv_cnt      = 2;
                    rv_addr     = mem_addr;
                end
            end
        end
        prev_req <= reset ? 1'b0 : mem_req;
        prev_bus <= {mem_we, mem_addr, mem_wdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input bit ld, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                            input logic [ADDR_W-1:0] exp_a);
        write_ld  = ld;
        writeaddr = a;
        write_req = 1'b1;
        writedata = d;
        exp_wr.push_back('{exp_a, d});
        tick();
        write_ld  = 1'b0;
        write_req = 1'b0;
    endtask

    task automatic read_load(input logic [ADDR_W-1:0] a, input bit also_pop);
        rd_exp.delete();
        for (int i = 0; i < int'(DEPTH); i++) rd_exp.push_back(mem_val(a + ADDR_W'(i)));
        read_ld  = 1'b1;
        readaddr = a;
        read_req = also_pop;
        tick();
        read_ld  = 1'b0;
        read_req = 1'b0;
    endtask

    task automatic pop_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 200 && rd_buffer == 16'd0; k++) tick();
            chk({name, "_avail"}, 32'(rd_buffer != 16'd0), 32'(1));
            chk(name, 32'(readdata), (rd_exp.size() != 0) ? 32'(rd_exp.pop_front()) : 32'hDEAD);
            read_req = 1'b1;
            tick();
            read_req = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string name);
        for (int k = 0; k < 400 && rd_buffer != 16'(DEPTH); k++) tick();
        chk(name, 32'(rd_buffer), 32'(DEPTH));
    endtask

    task automatic wait_rd_acked(input logic [ADDR_W-1:0] a, input string name);
        for (int k = 0; k < 200 && !rd_acked; k++) tick();
        chk(name, 32'(rd_ack_addr), 32'(a));
    endtask

    typedef struct {
        logic              ld;
        logic [ADDR_W-1:0] addr;
        logic              req;
        logic [15:0]       data;
        logic              push;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_buf;
        logic              exp_ovf;
    } wvec_t;

    wvec_t vt [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Write-side vectors with the controller stalled: address wrap, fill, overflow, clear.
        vt[0]  = '{1'b1, 25'h1FFFFFE, 1'b1, 16'hA000, 1'b1, 25'h1FFFFFE, 16'd1, 1'b0};
        vt[1]  = '{1'b0, 25'h0,       1'b1, 16'hA001, 1'b1, 25'h1FFFFFF, 16'd2, 1'b0};
        vt[2]  = '{1'b0, 25'h0,       1'b1, 16'hA002, 1'b1, 25'h0000000, 16'd3, 1'b0};
        vt[3]  = '{1'b0, 25'h0,       1'b1, 16'hA003, 1'b1, 25'h0000001, 16'd4, 1'b0};
        vt[4]  = '{1'b0, 25'h0,       1'b1, 16'hA004, 1'b1, 25'h0000002, 16'd5, 1'b0};
        vt[5]  = '{1'b0, 25'h0,       1'b1, 16'hA005, 1'b1, 25'h0000003, 16'd6, 1'b0};
        vt[6]  = '{1'b0, 25'h0,       1'b1, 16'hA006, 1'b1, 25'h0000004, 16'd7, 1'b0};
        vt[7]  = '{1'b0, 25'h0,       1'b1, 16'hA007, 1'b1, 25'h0000005, 16'd8, 1'b0};
        vt[8]  = '{1'b0, 25'h0,       1'b1, 16'hA008, 1'b0, 25'h0000000, 16'd8, 1'b1};
        vt[9]  = '{1'b0, 25'h0,       1'b0, 16'h0000, 1'b0, 25'h0000000, 16'd8, 1'b1};
        vt[10] = '{1'b1, 25'h40,      1'b0, 16'h0000, 1'b0, 25'h0000000, 16'd8, 1'b0};

        reset = 1'b1;
        write_ld = 1'b0; writeaddr = '0; write_req = 1'b0; writedata = '0;
        read_ld = 1'b0; readaddr = '0; read_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_wr_buffer", 32'(wr_buffer), 32'(0));
        chk("rst_rd_buffer", 32'(rd_buffer), 32'(0));
        chk("rst_wr_ovf", 32'(wr_ovf), 32'(0));
        chk("rst_readdata", 32'(readdata), 32'(0));

        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        chk("pop_empty_rd_buffer", 32'(rd_buffer), 32'(0));

        // Single posted write.
        do_write(1'b1, 25'h5653, 16'h6293, 25'h5653);
        chk("t1_wr_buffer_1", 32'(wr_buffer), 32'(1));
        for (int k = 0; k < 100 && wr_buffer != 16'd0; k++) tick();
        chk("t1_wr_buffer_0", 32'(wr_buffer), 32'(0));

        // Fill and overflow while the controller refuses to ack.
        ack_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            write_ld  = vt[i].ld;
            writeaddr = vt[i].addr;
            write_req = vt[i].req;
            writedata = vt[i].data;
            if (vt[i].push) exp_wr.push_back('{vt[i].exp_addr, vt[i].data});
            tick();
            write_ld  = 1'b0;
            write_req = 1'b0;
            chk($sformatf("vec%0d_wr_buffer", i), 32'(wr_buffer), 32'(vt[i].exp_buf));
            chk($sformatf("vec%0d_wr_ovf", i), 32'(wr_ovf), 32'(vt[i].exp_ovf));
        end
        ack_en = 1'b1;
        for (int k = 0; k < 200 && wr_buffer != 16'd0; k++) tick();
        chk("t3_drained", 32'(wr_buffer), 32'(0));
        chk("t3_scoreboard_empty", 32'(exp_wr.size()), 32'(0));

        // Prefetch from a loaded address.
        mem[32'h0E08] = 16'h7D59;
        mem[32'h0E09] = 16'h1234;
        read_load(25'h0E08, 1'b0);
        for (int k = 0; k < 100 && rd_buffer == 16'd0; k++) tick();
        chk("t2_rd_buffer_ge1", 32'(rd_buffer != 16'd0), 32'(1));
        pop_check(3, "t2_readdata");
        wait_quiet("t2_full");

        // Reload while a read awaits rvalid: its word must be dropped.
        rv_hold  = 1'b1;
        rd_acked = 1'b0;
        read_load(25'h100, 1'b0);
        wait_rd_acked(25'h100, "t4_first_read_addr");
        read_load(25'h200, 1'b0);
        chk("t4_flushed", 32'(rd_buffer), 32'(0));
        rv_hold = 1'b0;
        pop_check(3, "t4_readdata");
        wait_quiet("t4_full");

        // Pending writes beat prefetch; read_ld with read_req does not pop.
        log_q.delete();
        do_write(1'b1, 25'h300, 16'hB000, 25'h300);
        do_write(1'b0, 25'h0,   16'hB001, 25'h301);
        do_write(1'b0, 25'h0,   16'hB002, 25'h302);
        read_load(25'h300, 1'b1);
        rd_exp.delete();
        rd_exp.push_back(16'hB000);
        rd_exp.push_back(16'hB001);
        rd_exp.push_back(16'hB002);
        pop_check(3, "t5_readdata");
        chk("t5_log_size", 32'(log_q.size() >= 4), 32'(1));
        if (log_q.size() >= 4) begin
            chk("t5_order", 32'({log_q[0].we, log_q[1].we, log_q[2].we, log_q[3].we}), 32'(4'b1110));
            chk("t5_first_rd_addr", 32'(log_q[3].addr), 32'(25'h300));
        end
        wait_quiet("t5_full");

        // Reset while waiting for read data; a late rvalid must be ignored.
        rv_hold  = 1'b1;
        rd_acked = 1'b0;
        read_load(25'h400, 1'b0);
        wait_rd_acked(25'h400, "t6_read_addr");
        tick();
        reset = 1'b1;
        tick();
        chk("t6_mem_req", 32'(mem_req), 32'(0));
        chk("t6_mem_we", 32'(mem_we), 32'(0));
        chk("t6_mem_addr", 32'(mem_addr), 32'(0));
        chk("t6_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("t6_rd_buffer", 32'(rd_buffer), 32'(0));
        chk("t6_wr_buffer", 32'(wr_buffer), 32'(0));
        reset = 1'b0;
        rv_hold = 1'b0;
        repeat (6) tick();
        chk("t6_late_rvalid_rd_buffer", 32'(rd_buffer), 32'(0));
        chk("t6_late_rvalid_readdata", 32'(readdata), 32'(0));
        chk("t6_idle_mem_req", 32'(mem_req), 32'(0));
        chk("final_scoreboard_empty", 32'(exp_wr.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
